// File: rtl/alu_mc.sv
// alu_mc: width-generic multi-cycle ALU for the PIC16F-style core.
// Single-cycle byte ops complete one cycle after acceptance. Unsigned mul
// (shift-add) and div (restoring) iterate once per bit. All outputs are
// registered, and results and flag values hold until the next done pulse.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_w,
    input  logic [WIDTH-1:0] op_lf,
    input  logic             c_in,
    input  logic             d,
    input  logic             d_wr_en,
    input  logic             status_wr_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             w_wr_en,
    output logic             f_wr_en,
    output logic             z,
    output logic             dc,
    output logic             c,
    output logic             z_wr_en,
    output logic             dc_wr_en,
    output logic             c_wr_en
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_AND    = 4'd1;
    localparam logic [3:0] OP_CLR    = 4'd2;
    localparam logic [3:0] OP_COM    = 4'd3;
    localparam logic [3:0] OP_DEC    = 4'd4;
    localparam logic [3:0] OP_INC    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_PASSLF = 4'd7;
    localparam logic [3:0] OP_PASSW  = 4'd8;
    localparam logic [3:0] OP_RLF    = 4'd9;
    localparam logic [3:0] OP_RRF    = 4'd10;
    localparam logic [3:0] OP_SUB    = 4'd11;
    localparam logic [3:0] OP_SWAPF  = 4'd12;
    localparam logic [3:0] OP_XOR    = 4'd13;
    localparam logic [3:0] OP_MUL    = 4'd14;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Control state
    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           pend_q;      // single-cycle op accepted last cycle

    // Captured operands of the op in flight
    logic [3:0]       cap_op_q;
    logic [WIDTH-1:0] cap_w_q;
    logic [WIDTH-1:0] cap_lf_q;
    logic             cap_cin_q;
    logic             cap_d_q;
    logic             cap_dwr_q;
    logic             cap_swr_q;

    // Iterative datapath: mul holds {partial high, multiplier/low},
    // div holds {remainder, dividend/quotient}
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] iter_hi_d;
    logic [WIDTH-1:0] iter_lo_d;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             w_wr_en_q;
    logic             f_wr_en_q;
    logic             z_q;
    logic             dc_q;
    logic             c_q;
    logic             z_wr_en_q;
    logic             dc_wr_en_q;
    logic             c_wr_en_q;

    // Single-cycle ALU combinational results
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_dc_s;
    logic             alu_zwr_s;   // op affects Z
    logic             alu_dcwr_s;  // op affects DC
    logic             alu_cwr_s;   // op affects C

    // Iteration helpers
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_sub_s;
    logic             div_zero_s;

    assign sum_s      = {1'b0, cap_w_q} + {1'b0, cap_lf_q};
    assign div_zero_s = (cap_w_q == W_ZERO);

    // Result and flag behaviour of the single-cycle operations
    always_comb begin
        alu_res_s  = W_ZERO;
        alu_c_s    = 1'b0;
        alu_dc_s   = 1'b0;
        alu_zwr_s  = 1'b0;
        alu_dcwr_s = 1'b0;
        alu_cwr_s  = 1'b0;
        case (cap_op_q)
            OP_ADD: begin
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_c_s    = sum_s[WIDTH];
                alu_dc_s   = (({1'b0, cap_w_q[3:0]} + {1'b0, cap_lf_q[3:0]}) > 5'd15);
                alu_zwr_s  = 1'b1;
                alu_dcwr_s = 1'b1;
                alu_cwr_s  = 1'b1;
            end
            OP_SUB: begin
                // C and DC are not-borrow flags
                alu_res_s  = cap_lf_q - cap_w_q;
                alu_c_s    = (cap_lf_q >= cap_w_q);
                alu_dc_s   = (cap_lf_q[3:0] >= cap_w_q[3:0]);
                alu_zwr_s  = 1'b1;
                alu_dcwr_s = 1'b1;
                alu_cwr_s  = 1'b1;
            end
            OP_AND: begin
                alu_res_s = cap_w_q & cap_lf_q;
                alu_zwr_s = 1'b1;
            end
            OP_CLR: begin
                alu_res_s = W_ZERO;
                alu_zwr_s = 1'b1;
            end
            OP_COM: begin
                alu_res_s = ~cap_lf_q;
                alu_zwr_s = 1'b1;
            end
            OP_DEC: begin
                alu_res_s = cap_lf_q - W_ONE;
                alu_zwr_s = 1'b1;
            end
            OP_INC: begin
                alu_res_s = cap_lf_q + W_ONE;
                alu_zwr_s = 1'b1;
            end
            OP_OR: begin
                alu_res_s = cap_w_q | cap_lf_q;
                alu_zwr_s = 1'b1;
            end
            OP_PASSLF: begin
                alu_res_s = cap_lf_q;
                alu_zwr_s = 1'b1;
            end
            OP_PASSW: begin
                alu_res_s = cap_w_q;
                alu_zwr_s = 1'b1;
            end
            OP_XOR: begin
                alu_res_s = cap_w_q ^ cap_lf_q;
                alu_zwr_s = 1'b1;
            end
            OP_RLF: begin
                alu_res_s = {cap_lf_q[WIDTH-2:0], cap_cin_q};
                alu_c_s   = cap_lf_q[WIDTH-1];
                alu_cwr_s = 1'b1;
            end
            OP_RRF: begin
                alu_res_s = {cap_cin_q, cap_lf_q[WIDTH-1:1]};
                alu_c_s   = cap_lf_q[0];
                alu_cwr_s = 1'b1;
            end
            OP_SWAPF: begin
                alu_res_s = {cap_lf_q[WIDTH/2-1:0], cap_lf_q[WIDTH-1:WIDTH/2]};
            end
            default: begin
                // mul/div results come from the iterative datapath
                alu_res_s = W_ZERO;
            end
        endcase
    end

    // Next accumulator value for one mul (shift-add) or div (restoring) step
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) begin
            mul_sum_s = {1'b0, acc_hi_q} + {1'b0, cap_lf_q};
        end else begin
            mul_sum_s = {1'b0, acc_hi_q};
        end
        rem_sh_s  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge_s  = (rem_sh_s >= {1'b0, cap_w_q});
        // When the trial subtraction succeeds the true difference is below
        // the divisor, so the low WIDTH bits are exact.
        div_sub_s = rem_sh_s[WIDTH-1:0] - cap_w_q;
        if (cap_op_q == OP_MUL) begin
            iter_hi_d = mul_sum_s[WIDTH:1];
            iter_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
        end else if (div_ge_s) begin
            iter_hi_d = div_sub_s;
            iter_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            iter_hi_d = rem_sh_s[WIDTH-1:0];
            iter_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, operand capture, iteration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            pend_q      <= 1'b0;
            cap_op_q    <= 4'd0;
            cap_w_q     <= W_ZERO;
            cap_lf_q    <= W_ZERO;
            cap_cin_q   <= 1'b0;
            cap_d_q     <= 1'b0;
            cap_dwr_q   <= 1'b0;
            cap_swr_q   <= 1'b0;
            acc_hi_q    <= W_ZERO;
            acc_lo_q    <= W_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= W_ZERO;
            result_hi_q <= W_ZERO;
            w_wr_en_q   <= 1'b0;
            f_wr_en_q   <= 1'b0;
            z_q         <= 1'b0;
            dc_q        <= 1'b0;
            c_q         <= 1'b0;
            z_wr_en_q   <= 1'b0;
            dc_wr_en_q  <= 1'b0;
            c_wr_en_q   <= 1'b0;
        end else begin
            // Pulse and strobes are zero unless this edge completes an op
            done_q     <= 1'b0;
            w_wr_en_q  <= 1'b0;
            f_wr_en_q  <= 1'b0;
            z_wr_en_q  <= 1'b0;
            dc_wr_en_q <= 1'b0;
            c_wr_en_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    pend_q <= 1'b0;
                    if (pend_q) begin
                        result_q    <= alu_res_s;
                        result_hi_q <= W_ZERO;
                        z_q         <= (alu_res_s == W_ZERO);
                        if (alu_cwr_s) begin
                            c_q <= alu_c_s;
                        end
                        if (alu_dcwr_s) begin
                            dc_q <= alu_dc_s;
                        end
                        z_wr_en_q   <= cap_swr_q & alu_zwr_s;
                        dc_wr_en_q  <= cap_swr_q & alu_dcwr_s;
                        c_wr_en_q   <= cap_swr_q & alu_cwr_s;
                        w_wr_en_q   <= cap_dwr_q & ~cap_d_q;
                        f_wr_en_q   <= cap_dwr_q & cap_d_q;
                        done_q      <= 1'b1;
                    end
                    if (start) begin
                        cap_op_q  <= op;
                        cap_w_q   <= op_w;
                        cap_lf_q  <= op_lf;
                        cap_cin_q <= c_in;
                        cap_d_q   <= d;
                        cap_dwr_q <= d_wr_en;
                        cap_swr_q <= status_wr_en;
                        if (op >= OP_MUL) begin
                            state_q  <= S_RUN;
                            cnt_q    <= CNT_LOAD;
                            acc_hi_q <= W_ZERO;
                            if (op == OP_MUL) begin
                                acc_lo_q <= op_w;
                            end else begin
                                acc_lo_q <= op_lf;
                            end
                        end else begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_q    <= cnt_q - CNT_ONE;
                        busy_q   <= 1'b1;
                        acc_hi_q <= iter_hi_d;
                        acc_lo_q <= iter_lo_d;
                    end else begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        result_q    <= acc_lo_q;
                        result_hi_q <= acc_hi_q;
                        if (cap_op_q == OP_MUL) begin
                            z_q <= ({acc_hi_q, acc_lo_q} == {(2*WIDTH){1'b0}});
                        end else begin
                            // Divide by zero naturally yields all-ones quotient
                            // and the dividend as remainder.
                            z_q       <= (acc_lo_q == W_ZERO);
                            c_q       <= div_zero_s;
                            c_wr_en_q <= cap_swr_q;
                        end
                        z_wr_en_q <= cap_swr_q;
                        w_wr_en_q <= cap_dwr_q & ~cap_d_q;
                        f_wr_en_q <= cap_dwr_q & cap_d_q;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign w_wr_en   = w_wr_en_q;
    assign f_wr_en   = f_wr_en_q;
    assign z         = z_q;
    assign dc        = dc_q;
    assign c         = c_q;
    assign z_wr_en   = z_wr_en_q;
    assign dc_wr_en  = dc_wr_en_q;
    assign c_wr_en   = c_wr_en_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=8 and WIDTH=16.
module tb_alu_mc;

    localparam logic [3:0] ADD = 4'd0, AND = 4'd1, CLR = 4'd2, COM = 4'd3,
                           DEC = 4'd4, INC = 4'd5, OR = 4'd6, PASSLF = 4'd7,
                           PASSW = 4'd8, RLF = 4'd9, RRF = 4'd10, SUB = 4'd11,
                           SWAPF = 4'd12, XOR = 4'd13, MUL = 4'd14, DIV = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start8, start16, c_in, d, d_wr_en, status_wr_en;
    logic [3:0]  op;
    logic [15:0] op_w, op_lf;

    logic        busy8, done8, w_wr8, f_wr8, z8, dc8, c8, zwr8, dcwr8, cwr8;
    logic [7:0]  result8, result_hi8;
    logic        busy16, done16, w_wr16, f_wr16, z16, dc16, c16, zwr16, dcwr16, cwr16;
    logic [15:0] result16, result_hi16;

    alu_mc #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .op_w(op_w[7:0]), .op_lf(op_lf[7:0]),
        .c_in(c_in), .d(d), .d_wr_en(d_wr_en), .status_wr_en(status_wr_en),
        .busy(busy8), .done(done8), .result(result8), .result_hi(result_hi8),
        .w_wr_en(w_wr8), .f_wr_en(f_wr8), .z(z8), .dc(dc8), .c(c8),
        .z_wr_en(zwr8), .dc_wr_en(dcwr8), .c_wr_en(cwr8)
    );

    alu_mc #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op), .op_w(op_w), .op_lf(op_lf),
        .c_in(c_in), .d(d), .d_wr_en(d_wr_en), .status_wr_en(status_wr_en),
        .busy(busy16), .done(done16), .result(result16), .result_hi(result_hi16),
        .w_wr_en(w_wr16), .f_wr_en(f_wr16), .z(z16), .dc(dc16), .c(c16),
        .z_wr_en(zwr16), .dc_wr_en(dcwr16), .c_wr_en(cwr16)
    );

    typedef struct {
        string       name;
        int          cyc;
        int          busyc;
        logic [15:0] res;
        logic [15:0] hi;
        logic        z, c, dc, zw, dcw, cw, ww, fw;
        bit          chc, chdc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   nvec  = 0;
    int   nfail = 0;
    int   cyc   = 0;
    int   brun8 = 0;
    int   brun16 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string n, input logic [15:0] r, h,
                                input logic ez, ec, edc, zw, dcw, cw, ww, fw,
                                input bit chc, chdc);
        exp_t e;
        e.name = n; e.cyc = 0; e.busyc = 0; e.res = r; e.hi = h;
        e.z = ez; e.c = ec; e.dc = edc; e.zw = zw; e.dcw = dcw; e.cw = cw;
        e.ww = ww; e.fw = fw; e.chc = chc; e.chdc = chdc;
        return e;
    endfunction

    task automatic chk(input exp_t e, input int br, input logic [15:0] r, h,
                       input logic az, ac, adc, zw, dcw, cw, ww, fw);
        bit bad;
        nvec++;
        bad = (cyc != e.cyc) || (br != e.busyc) || (r !== e.res) || (h !== e.hi) ||
              (az !== e.z) || (e.chc && (ac !== e.c)) || (e.chdc && (adc !== e.dc)) ||
              ({zw, dcw, cw, ww, fw} !== {e.zw, e.dcw, e.cw, e.ww, e.fw});
        if (bad) begin
            nfail++;
            $display("FAIL %s: got cyc=%0d busy=%0d res=%h hi=%h z=%b c=%b dc=%b str(z,dc,c,w,f)=%b%b%b%b%b; want cyc=%0d busy=%0d res=%h hi=%h z=%b c=%b dc=%b str=%b%b%b%b%b",
                     e.name, cyc, br, r, h, az, ac, adc, zw, dcw, cw, ww, fw,
                     e.cyc, e.busyc, e.res, e.hi, e.z, e.c, e.dc, e.zw, e.dcw, e.cw, e.ww, e.fw);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            brun8 = 0;
        end else begin
            if (busy8 === 1'b1) brun8++;
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL unexpected_done8: got done=1 res=%h at cyc=%0d, want no done", result8, cyc);
                end else begin
                    e = q8.pop_front();
                    chk(e, brun8, {8'h00, result8}, {8'h00, result_hi8}, z8, c8, dc8,
                        zwr8, dcwr8, cwr8, w_wr8, f_wr8);
                end
                brun8 = 0;
            end else if ({zwr8, dcwr8, cwr8, w_wr8, f_wr8} !== 5'b0) begin
                nvec++; nfail++;
                $display("FAIL stray_strobe8: got %b without done at cyc=%0d, want 00000",
                         {zwr8, dcwr8, cwr8, w_wr8, f_wr8}, cyc);
            end
        end
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            brun16 = 0;
        end else begin
            if (busy16 === 1'b1) brun16++;
            if (done16 === 1'b1) begin
                if (q16.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL unexpected_done16: got done=1 res=%h at cyc=%0d, want no done", result16, cyc);
                end else begin
                    e = q16.pop_front();
                    chk(e, brun16, result16, result_hi16, z16, c16, dc16,
                        zwr16, dcwr16, cwr16, w_wr16, f_wr16);
                end
                brun16 = 0;
            end
        end
    end

    task automatic issue(input bit w16, input logic [3:0] o, input logic [15:0] w, lf,
                         input logic ci, dd, dw, sw, input bit push, input exp_t e);
        op = o; op_w = w; op_lf = lf; c_in = ci; d = dd; d_wr_en = dw; status_wr_en = sw;
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        if (push) begin
            e.cyc   = cyc + ((o >= MUL) ? (w16 ? 17 : 9) : 1);
            e.busyc = (o >= MUL) ? (w16 ? 16 : 8) : 0;
            if (w16) q16.push_back(e); else q8.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout: got %0d/%0d pending, want 0/0", q8.size(), q16.size());
            q8.delete(); q16.delete();
        end
    endtask

    initial begin
        exp_t none;
        bit ok;
        none = mk("none", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; op = 4'd0; op_w = 16'h0; op_lf = 16'h0;
        c_in = 1'b0; d = 1'b0; d_wr_en = 1'b0; status_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({busy8, done8, result8, result_hi8, w_wr8, f_wr8, z8, dc8, c8, zwr8, dcwr8, cwr8} !== 26'h0) begin
            nfail++; $display("FAIL reset8: got nonzero outputs res=%h hi=%h, want all 0", result8, result_hi8);
        end
        nvec++;
        if ({busy16, done16, result16, result_hi16, w_wr16, f_wr16, z16, dc16, c16, zwr16, dcwr16, cwr16} !== 42'h0) begin
            nfail++; $display("FAIL reset16: got nonzero outputs res=%h hi=%h, want all 0", result16, result_hi16);
        end
        rst = 1'b0;

        // Back-to-back single-cycle ops, WIDTH=8
        //          w16 op      op_w    op_lf   ci    d     dwr   swr
        issue(0, ADD,    16'hFF, 16'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("add_ff_01", 16'h00, 16'h0, 1,1,1, 1,1,1, 0,1, 1,1));
        issue(0, ADD,    16'h08, 16'h08, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("add_dc",    16'h10, 16'h0, 0,0,1, 1,1,1, 1,0, 1,1));
        issue(0, SUB,    16'h05, 16'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("sub_eq",    16'h00, 16'h0, 1,1,1, 1,1,1, 1,0, 1,1));
        issue(0, SUB,    16'h05, 16'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("sub_brw",   16'hFE, 16'h0, 0,0,0, 1,1,1, 0,1, 1,1));
        issue(0, RRF,    16'h00, 16'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1, mk("rrf",       16'h80, 16'h0, 0,1,0, 0,0,1, 0,1, 1,0));
        issue(0, RLF,    16'h00, 16'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("rlf",       16'h02, 16'h0, 0,1,0, 0,0,1, 1,0, 1,0));
        issue(0, AND,    16'hF0, 16'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("and",       16'h30, 16'h0, 0,0,0, 1,0,0, 1,0, 0,0));
        issue(0, XOR,    16'h3C, 16'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("xor",       16'h00, 16'h0, 1,0,0, 1,0,0, 0,1, 0,0));
        issue(0, OR,     16'h50, 16'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1, mk("or_nowr",   16'h55, 16'h0, 0,0,0, 0,0,0, 0,0, 0,0));
        issue(0, CLR,    16'h12, 16'h34, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("clr",       16'h00, 16'h0, 1,0,0, 1,0,0, 0,1, 0,0));
        issue(0, COM,    16'h00, 16'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("com",       16'hF0, 16'h0, 0,0,0, 1,0,0, 1,0, 0,0));
        issue(0, DEC,    16'h00, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("dec_wrap",  16'hFF, 16'h0, 0,0,0, 1,0,0, 1,0, 0,0));
        issue(0, INC,    16'h00, 16'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("inc_wrap",  16'h00, 16'h0, 1,0,0, 1,0,0, 1,0, 0,0));
        issue(0, PASSW,  16'h77, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("passw",     16'h77, 16'h0, 0,0,0, 1,0,0, 1,0, 0,0));
        issue(0, PASSLF, 16'h77, 16'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("passlf",    16'h00, 16'h0, 1,0,0, 1,0,0, 0,1, 0,0));
        issue(0, SWAPF,  16'h00, 16'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("swapf",     16'h5A, 16'h0, 0,0,0, 0,0,0, 0,1, 0,0));
        drain();

        // mul with an ignored mid-run start and changing inputs
        issue(0, MUL, 16'h11, 16'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("mul_0f_11", 16'hFF, 16'h00, 0,0,0, 1,0,0, 1,0, 0,0));
        repeat (3) @(posedge clk);
        #1;
        op = INC; op_w = 16'h99; op_lf = 16'h66; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        drain();

        issue(0, DIV, 16'h07, 16'hC8, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("div_c8_07", 16'h1C, 16'h04, 0,0,0, 1,0,1, 0,1, 1,0));
        drain();
        issue(0, DIV, 16'h00, 16'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("div_by_0",  16'hFF, 16'h42, 0,1,0, 1,0,1, 0,1, 1,0));
        drain();
        issue(0, MUL, 16'h00, 16'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("mul_zero",  16'h00, 16'h00, 1,0,0, 1,0,0, 1,0, 0,0));
        drain();

        // inc issued in the done cycle of a div
        issue(0, DIV, 16'h07, 16'hC8, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("div_b2b",   16'h1C, 16'h04, 0,0,0, 1,0,1, 1,0, 1,0));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            nvec++; nfail++;
            $display("FAIL div_done_wait: got no done in 20 cycles, want done");
        end
        issue(0, INC, 16'h00, 16'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("inc_b2b", 16'h42, 16'h0, 0,0,0, 1,0,0, 1,0, 0,0));
        drain();

        // Reset on RUN cycle 4 of a mul, together with a start
        issue(0, MUL, 16'h11, 16'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 0, none);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; op = INC; op_lf = 16'h10; start8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        nvec++;
        if ({busy8, done8, result8, result_hi8, w_wr8, f_wr8, z8, dc8, c8, zwr8, dcwr8, cwr8} !== 26'h0) begin
            nfail++;
            $display("FAIL reset_abort: got busy=%b done=%b res=%h hi=%h, want all 0", busy8, done8, result8, result_hi8);
        end
        repeat (14) @(negedge clk);

        // WIDTH=16
        issue(1, ADD,   16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("add16_dc", 16'h0100, 16'h0, 0,0,1, 1,1,1, 0,1, 1,1));
        issue(1, SWAPF, 16'h0000, 16'h12AB, 1'b0, 1'b1, 1'b1, 1'b1, 1, mk("swapf16",  16'hAB12, 16'h0, 0,0,0, 0,0,0, 0,1, 0,0));
        drain();
        issue(1, MUL,   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk("mul16_max", 16'h0001, 16'hFFFE, 0,0,0, 1,0,0, 1,0, 0,0));
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the PIC16F-style core: it executes all the single-cycle byte operations, plus unsigned multiply and divide, over a `start`/`busy`/`done` handshake. It sits between the W register / register-file read mux and the writeback/STATUS logic. It is the width-generic successor to the fixed 8-bit combinational ALU. Every output is registered, so the controller stalls on `busy` instead of absorbing long combinational paths.

## Interface
- `WIDTH`, default 8: datapath width. Must be even and at least 8.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only when idle.
- `op` input 4: operation code. 0 add, 1 and, 2 clr, 3 com, 4 dec, 5 inc, 6 or, 7 passlf, 8 passw, 9 rlf, 10 rrf, 11 sub, 12 swapf, 13 xor, 14 mul, 15 div.
- `op_w` input WIDTH: W operand.
- `op_lf` input WIDTH: literal or file-register operand.
- `c_in` input 1: STATUS carry, used by rlf/rrf.
- `d` input 1: destination select, 0 = W, 1 = f.
- `d_wr_en` input 1: destination write permitted.
- `status_wr_en` input 1: STATUS write permitted.
- `busy` output 1: a multi-cycle op is in progress.
- `done` output 1: one-cycle pulse; results are valid from this cycle.
- `result` output WIDTH: primary result. Product low half for mul, quotient for div.
- `result_hi` output WIDTH: product high half for mul, remainder for div, 0 otherwise.
- `w_wr_en`, `f_wr_en` output 1 each: destination write strobes.
- `z`, `dc`, `c` output 1 each: flag values.
- `z_wr_en`, `dc_wr_en`, `c_wr_en` output 1 each: flag write strobes.

## Operation
- **Operand capture.** On accept, capture `op`, `op_w`, `op_lf`, `c_in`, `d`, `d_wr_en` and `status_wr_en`. Later input changes have no effect on the op in flight.
- **Write strobes.** All strobes are asserted only in the `done` cycle and are 0 at all other times.
  - `w_wr_en` = `d_wr_en` & ~`d`.
  - `f_wr_en` = `d_wr_en` & `d`.
  - Each flag strobe equals `status_wr_en` for the ops listed below, and is 0 otherwise.
- **add.** `result` = (`op_w` + `op_lf`) mod 2^WIDTH.
  - `c` = carry out of the MSB.
  - `dc` = carry out of bit 3.
  - Writes Z, DC and C.
- **sub.** `result` = `op_lf` − `op_w`.
  - `c` = 1 when `op_lf` ≥ `op_w` (C = not-borrow).
  - `dc` = 1 when there is no borrow out of bit 3.
  - Writes Z, DC and C.
- **Ops writing Z only:** and, clr (result 0, `z`=1), com (~`op_lf`), dec and inc (`op_lf` ∓ 1, wrapping), or, passlf, passw, xor.
- **rlf.** `result` = {`op_lf`[WIDTH-2:0], `c_in`}, `c` = `op_lf`[WIDTH-1]. Writes C only.
- **rrf.** `result` = {`c_in`, `op_lf`[WIDTH-1:1]}, `c` = `op_lf`[0]. Writes C only.
- **swapf.** Exchanges the upper and lower WIDTH/2 halves of `op_lf`. Writes no flags.
- **Zero flag.** `z` = 1 when `result` is 0. For mul, `z` = 1 only when the full 2·WIDTH-bit product is 0.
- **mul.** Unsigned shift-add: `op_lf` × `op_w` → {`result_hi`, `result`}. Writes Z. C and DC are untouched.
- **div.** Unsigned restoring division: `op_lf` ÷ `op_w`. Quotient goes to `result`, remainder to `result_hi`. Writes Z and C, with `c` = 1 on divide-by-zero.
- **Divide by zero.** `op_w` = 0 gives `result` = all ones, `result_hi` = `op_lf`, `c` = 1, and still takes full latency.
- **States.** IDLE, RUN.
  - IDLE & `start` & op < 14: stay IDLE, pulse `done` next cycle.
  - IDLE & `start` & op ≥ 14: go to RUN, load the iteration counter with WIDTH.
  - RUN: one iteration per cycle. When the counter reaches 0, go to IDLE and pulse `done`.
- **Output hold.** `result`, `result_hi` and the flag values hold after `done` until the next `done`.

## Timing
- **Reset.** Every output is 0, state is IDLE and the counter is 0.
- **Reset during RUN.** Abort the op, return to IDLE, and do not pulse `done` for it.
- **Single-cycle ops.** `start` sampled high at edge k gives `done`=1 with valid outputs after edge k+1. `busy` stays 0.
- **mul/div.**
  - `busy`=1 after edges k+1 through k+WIDTH.
  - After edge k+WIDTH+1: `done`=1 and `busy`=0.
  - Latency is WIDTH+1 cycles, independent of operand values.
- **`start` while busy.** Ignored and not queued.
- **`start` in the `done` cycle.** Accepted, which allows back-to-back issue. Single-cycle ops can sustain one op per cycle.
- **`done` width.** Exactly one cycle per accepted op.
- **Simultaneous `rst` and `start`.** `rst` wins.

## Test plan
- **add, WIDTH=8:** `op_w`=0xFF, `op_lf`=0x01, `status_wr_en`=1, `d`=1, `d_wr_en`=1 → `done` after 1 cycle, `result`=0x00, `z`=1, `dc`=1, `c`=1, `f_wr_en`=1, `w_wr_en`=0.
- **sub/rrf:**
  - sub with `op_lf`=0x05, `op_w`=0x05 → `result`=0x00, `z`=1, `c`=1, `dc`=1.
  - sub with `op_lf`=0x03, `op_w`=0x05 → `result`=0xFE, `c`=0, `dc`=0.
  - rrf with 0x01, `c_in`=1 → `result`=0x80, `c`=1, `z_wr_en`=0.
- **mul:** 0x0F × 0x11 → `busy` for exactly 8 cycles, then `result`=0xFF, `result_hi`=0x00, `z`=0. A `start` issued mid-run is ignored.
- **div:** 0xC8 ÷ 0x07 → after 9 cycles `result`=0x1C, `result_hi`=0x04, `c`=0. 0x42 ÷ 0x00 → `result`=0xFF, `result_hi`=0x42, `c`=1.
- **Reset and back-to-back:**
  - `rst` asserted on RUN cycle 4 of a mul → no `done` pulse, all outputs 0 next cycle.
  - inc issued on the `done` cycle of a div → second `done` exactly 1 cycle later.
- **WIDTH=16:**
  - swapf 0x12AB → 0xAB12.
  - mul 0xFFFF × 0xFFFF → `result`=0x0001, `result_hi`=0xFFFE after 17 cycles.
